// File: rtl/ctrl_weight_loader.sv
// Captures a weight matrix on start and streams it one PE row per w_valid/w_ready handshake, top index first.
// First row is presented the cycle after start; each w_ready=0 cycle adds one cycle; done pulses after the row-0 handshake.
module ctrl_weight_loader #(
    parameter int WEIGHT_BW   = 8,
    parameter int NUM_PE_ROWS = 8,
    parameter int MATRIX_SIZE = 8,
    localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE,
    localparam int MAT_W = ROW_W * NUM_PE_ROWS,
    localparam int CW    = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MAT_W-1:0] weight_in,
    input  logic             w_ready,
    output logic [ROW_W-1:0] w_row_data,
    output logic [CW-1:0]    w_row_idx,
    output logic             w_valid,
    output logic             w_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] TOP_ROW = CW'(NUM_PE_ROWS - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [MAT_W-1:0] wbuf;

    logic [CW-1:0]    cnt_dec;
    logic [ROW_W-1:0] top_row_in;
    logic [ROW_W-1:0] next_row;

    // Row presented on the capture edge comes straight from weight_in since wbuf is loaded on the same edge.
    assign cnt_dec    = cnt - CW'(1);
    assign top_row_in = weight_in[(NUM_PE_ROWS-1)*ROW_W +: ROW_W];
    assign next_row   = wbuf[int'(cnt_dec)*ROW_W +: ROW_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= TOP_ROW;
            wbuf       <= '0;
            w_row_data <= '0;
            w_row_idx  <= '0;
            w_valid    <= 1'b0;
            w_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        wbuf       <= weight_in;
                        cnt        <= TOP_ROW;
                        state      <= LOAD;
                        w_valid    <= 1'b1;
                        busy       <= 1'b1;
                        w_row_data <= top_row_in;
                        w_row_idx  <= TOP_ROW;
                        w_last     <= (TOP_ROW == '0);
                    end
                end
                LOAD: begin
                    if (w_valid && w_ready) begin
                        if (cnt == '0) begin
                            state      <= DONE;
                            w_valid    <= 1'b0;
                            busy       <= 1'b0;
                            w_last     <= 1'b0;
                            w_row_data <= '0;
                            w_row_idx  <= '0;
                            done       <= 1'b1;
                        end else begin
                            cnt        <= cnt_dec;
                            w_row_data <= next_row;
                            w_row_idx  <= cnt_dec;
                            w_last     <= (cnt_dec == '0);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    w_row_data <= '0;
                    w_row_idx  <= '0;
                    w_valid    <= 1'b0;
                    w_last     <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
